// File: rtl/mem_stream_reader.sv
// Streaming read engine for memory_block: issues sequential reads, realigns the returned
// words against the fixed RAM read latency and buffers them onto a valid/ready stream.
module mem_stream_reader #(
  parameter int DATAW      = 8,
  parameter int DEPTH      = 512,
  parameter int ADDRW      = $clog2(DEPTH),
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   length,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int PTRW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNTW = $clog2(BUF_DEPTH + 1);
  localparam int UW   = $clog2(BUF_DEPTH + RD_LATENCY + 2) + 1;
  localparam int LW   = ADDRW + 1;
  // One stage lines up with the registered address, RD_LATENCY more cover the RAM.
  localparam int NSTG = RD_LATENCY + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           state_reg;
  logic [ADDRW-1:0] addr_reg;
  logic [LW-1:0]    remain_reg;
  logic [NSTG-1:0]  tag_valid_reg;
  logic [NSTG-1:0]  tag_last_reg;
  logic [DATAW-1:0] buf_data_reg [BUF_DEPTH];
  logic             buf_last_reg [BUF_DEPTH];
  logic [PTRW-1:0]  wr_ptr_reg;
  logic [PTRW-1:0]  rd_ptr_reg;
  logic [CNTW-1:0]  count_reg;

  logic             issue;
  logic             capture;
  logic             cap_last;
  logic             pop;
  logic [UW-1:0]    inflight;
  logic [UW-1:0]    used;
  logic [CNTW-1:0]  count_after_pop;
  logic [CNTW-1:0]  count_next;
  logic [PTRW-1:0]  rd_ptr_next;
  logic [DATAW-1:0] head_data_next;
  logic             head_last_next;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(BUF_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NSTG; i++) begin
      inflight = inflight + UW'(tag_valid_reg[i]);
    end
  end

  // A word popped this cycle frees its slot in time for a read issued on the same edge.
  assign pop             = out_valid & out_ready;
  assign capture         = tag_valid_reg[NSTG-1];
  assign cap_last        = tag_last_reg[NSTG-1];
  assign count_after_pop = count_reg - CNTW'(pop);
  assign used            = UW'(count_after_pop) + inflight;
  assign issue           = (state_reg == RUN) && (used < UW'(BUF_DEPTH));
  assign count_next      = count_after_pop + CNTW'(capture);
  assign rd_ptr_next     = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

  // Next head: the captured word bypasses the array when the buffer is otherwise empty.
  always_comb begin
    head_data_next = out_data;
    head_last_next = out_last;
    if (count_next != '0) begin
      if (count_after_pop == '0) begin
        head_data_next = mem_rdata;
        head_last_next = cap_last;
      end else begin
        head_data_next = buf_data_reg[rd_ptr_next];
        head_last_next = buf_last_reg[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_reg   <= '0;
      remain_reg <= '0;
      mem_raddr  <= '0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        mem_raddr  <= addr_reg;
        addr_reg   <= (addr_reg == ADDRW'(DEPTH - 1)) ? '0 : addr_reg + ADDRW'(1);
        remain_reg <= remain_reg - LW'(1);
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg   <= base_addr;
            remain_reg <= length;
            if (length == '0) begin
              state_reg <= FIN;
              done      <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (remain_reg == LW'(1))) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state_reg <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid_reg <= '0;
      tag_last_reg  <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[NSTG-2:0], issue};
      tag_last_reg  <= {tag_last_reg[NSTG-2:0], issue && (remain_reg == LW'(1))};
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_data_reg[wr_ptr_reg] <= mem_rdata;
      buf_last_reg[wr_ptr_reg] <= cap_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      out_valid  <= (count_next != '0);
      out_data   <= head_data_next;
      out_last   <= head_last_next;
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: RAM model with 2-cycle read latency, queue-based
// reference of the expected word stream, table of directed runs plus random runs.
module tb_mem_stream_reader;

  localparam int DEPTH = 512;
  localparam int BUFD  = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] base_addr;
  logic [9:0] length;
  logic       busy;
  logic       done;
  logic [8:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b0;

  mem_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM read port: address registered in the DUT, two more cycles to data.
  logic [7:0] ram [DEPTH];
  logic [7:0] rd_p1;
  always @(posedge clk) begin
    rd_p1     <= ram[mem_raddr];
    mem_rdata <= rd_p1;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    int base;
    int len;
    int mode;
    int exp_first;
    int exp_done;
  } run_vec_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;
  int   ready_mode  = 0;
  int   stall_cnt   = 0;
  int   hs_count    = 0;
  int   last_count  = 0;
  bit   prev_stalled = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic       r_sel;
  exp_t       e_mon;
  int         occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Output monitor: drives out_ready, checks each handshake against the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stalled) begin
        chk("stall_valid_held", 32'(out_valid), 1);
        chk("stall_data_held", 32'(out_data), 32'(prev_data));
        chk("stall_last_held", 32'(out_last), 32'(prev_last));
      end
      case (ready_mode)
        0: r_sel = 1'b1;
        1: r_sel = 1'($urandom_range(0, 1));
        default: begin
          if (stall_cnt > 0) begin
            r_sel = 1'b0;
            stall_cnt--;
          end else begin
            r_sel = 1'b1;
          end
        end
      endcase
      out_ready = r_sel;
      if (out_valid && r_sel) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got data %0d, required no word", out_data);
        end else begin
          e_mon = exp_q.pop_front();
          chk("word_data", 32'(out_data), 32'(e_mon.data));
          chk("word_last", 32'(out_last), 32'(e_mon.last));
        end
        hs_count++;
        if (out_last) last_count++;
        if (ready_mode == 2 && hs_count == 1) stall_cnt = 6;
      end
      prev_stalled = out_valid && !r_sel;
      prev_data    = out_data;
      prev_last    = out_last;
      occ = int'(dut.count_reg);
      for (int i = 0; i < 3; i++) occ += int'(dut.tag_valid_reg[i]);
      chk("buffer_no_overflow", 32'(occ <= BUFD), 1);
    end else begin
      out_ready    = 1'b0;
      prev_stalled = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_mem_raddr"}, 32'(mem_raddr), 0);
  endtask

  // Runs one command starting at a negedge; returns at the negedge after done.
  task automatic do_run(input int base, input int len, input int mode, input int exp_first,
                        input int exp_done, input bit second_start, input bit chk_addr);
    int c, first_c, done_c, idx, a;
    logic [8:0] last_a;
    ready_mode = mode;
    hs_count   = 0;
    last_count = 0;
    stall_cnt  = 0;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % DEPTH;
      exp_q.push_back('{data: ram[a], last: (i == len - 1)});
    end
    start     = 1'b1;
    base_addr = 9'(base);
    length    = 10'(len);
    last_a    = mem_raddr;
    idx = 0; first_c = -1; done_c = -1; c = 0;
    @(negedge clk);
    start = 1'b0;
    while (done_c < 0 && c < 4000) begin
      if (c == 0) chk("busy_after_start", 32'(busy), 32'(len != 0));
      if (len == 0) begin
        chk("len0_busy_low", 32'(busy), 0);
        chk("len0_valid_low", 32'(out_valid), 0);
      end
      if (out_valid && first_c < 0) first_c = c;
      if (chk_addr && mem_raddr != last_a) begin
        chk("mem_raddr_seq", 32'(mem_raddr), 32'((base + idx) % DEPTH));
        idx++;
        last_a = mem_raddr;
      end
      if (done) done_c = c;
      if (second_start && c == 10) begin
        start = 1'b1; base_addr = 9'd100; length = 10'd5;
      end else begin
        start = 1'b0;
      end
      if (done_c < 0) begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    if (done_c < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: got no done within 4000 cycles, required done (base %0d len %0d)", base, len);
    end
    $display("run base=%0d len=%0d mode=%0d: first_valid=%0d done_cycle=%0d", base, len, mode, first_c, done_c);
    chk("first_valid_cycle", 32'(first_c), 32'(exp_first));
    if (exp_done >= 0) chk("done_cycle", 32'(done_c), 32'(exp_done));
    chk("words_outstanding", 32'(exp_q.size()), 0);
    chk("last_count", 32'(last_count), 32'(len != 0));
    if (chk_addr) chk("addr_count", 32'(idx), 32'(len));
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_busy_low", 32'(busy), 0);
    chk("idle_valid_low", 32'(out_valid), 0);
  endtask

  run_vec_t tbl [6];
  int base_r, len_r, c;

  initial begin
    for (int k = 0; k < DEPTH; k++) ram[k] = k[7:0];
    rst = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    tbl[0] = '{base: 10,  len: 4, mode: 0, exp_first: 4,  exp_done: 8};
    tbl[1] = '{base: 10,  len: 4, mode: 2, exp_first: 4,  exp_done: 14};
    tbl[2] = '{base: 510, len: 4, mode: 0, exp_first: 4,  exp_done: 8};
    tbl[3] = '{base: 200, len: 0, mode: 0, exp_first: -1, exp_done: 0};
    tbl[4] = '{base: 7,   len: 1, mode: 0, exp_first: 4,  exp_done: 5};
    tbl[5] = '{base: 300, len: 9, mode: 0, exp_first: 4,  exp_done: 13};
    for (int t = 0; t < 6; t++) begin
      do_run(tbl[t].base, tbl[t].len, tbl[t].mode, tbl[t].exp_first, tbl[t].exp_done, 1'b0, 1'b1);
    end

    // Full-depth run under random backpressure, with an ignored start while busy.
    do_run(37, DEPTH, 1, 4, -1, 1'b1, 1'b1);

    // Random runs: even ones at full rate check exact completion time.
    for (int n = 0; n < 6; n++) begin
      len_r = int'($urandom_range(1, 40));
      do base_r = int'($urandom_range(0, DEPTH - 1)); while (base_r == int'(mem_raddr));
      if (n % 2 == 0) do_run(base_r, len_r, 0, 4, 4 + len_r, 1'b0, 1'b1);
      else            do_run(base_r, len_r, 1, 4, -1, 1'b0, 1'b1);
    end

    // Reset in the middle of a run after two words have been delivered.
    ready_mode = 0; hs_count = 0; last_count = 0;
    for (int i = 0; i < 20; i++) exp_q.push_back('{data: ram[50 + i], last: (i == 19)});
    start = 1'b1; base_addr = 9'd50; length = 10'd20;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (hs_count < 2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("midrun_two_words", 32'(hs_count >= 2), 1);
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    do_run(0, 3, 0, 4, 7, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
